// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, requester sides, tie-break rule.
// No logic of its own; imported by mem_port_arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    // On a tie the side that did not win last time goes next, giving strict alternation.
    function automatic side_t pick_side(input logic i_req, input logic d_req, input side_t last);
        if (i_req && d_req) begin
            return (last == SIDE_I) ? SIDE_D : SIDE_I;
        end
        return d_req ? SIDE_D : SIDE_I;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// WAIT-state watchdog for mem_port_arbiter; only built when ARB_TIMEOUT_EN is defined.
// expired is combinational in the TIMEOUT-th consecutive run cycle; clear restarts the count.
`ifdef ARB_TIMEOUT_EN
module mem_arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = run && (cnt == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory between fetch (read-only) and the memory stage; optional timeout via ARB_TIMEOUT_EN.
// Min 3 cycles request->done, next grant one cycle later; requesters stall (req & ~done) until their access completes.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    output logic          i_stall,

    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,

    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,

    output logic          err
);

    state_t state;
    state_t state_nxt;
    side_t  last_grant;
    side_t  grant_side;
    logic   grant_now;
    logic   take_data;
    logic   take_timeout;
    logic   timeout_hit;

`ifdef ARB_TIMEOUT_EN
    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ISSUE),
        .run     (state == WAIT),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_side   = pick_side(i_req, d_req, last_grant);
        grant_now    = 1'b0;
        take_data    = 1'b0;
        take_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_now = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // A real completion wins over a timeout landing in the same cycle.
                if (mem_done) begin
                    take_data = 1'b1;
                    state_nxt = RESP;
                end else if (timeout_hit) begin
                    take_timeout = 1'b1;
                    state_nxt    = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SIDE_I;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            mem_en <= (state_nxt == ISSUE);
            i_done <= (state_nxt == RESP) && (last_grant == SIDE_I);
            d_done <= (state_nxt == RESP) && (last_grant == SIDE_D);

            if (grant_now) begin
                last_grant <= grant_side;
                mem_wr     <= (grant_side == SIDE_D) && d_wr;
                mem_addr   <= (grant_side == SIDE_D) ? d_addr : i_addr;
                mem_wdata  <= (grant_side == SIDE_D) ? d_wdata : '0;
            end

            // Writes leave d_rdata alone, even when they time out.
            if (take_data || take_timeout) begin
                if (last_grant == SIDE_I) begin
                    i_rdata <= take_data ? mem_rdata : '0;
                end else if (!mem_wr) begin
                    d_rdata <= take_data ? mem_rdata : '0;
                end
            end

            if (take_timeout) begin
                err <= 1'b1;
            end
        end
    end

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-level model and bench-owned memory.
// Timeout behaviour is checked for whichever build (ARB_TIMEOUT_EN or not) is compiled.
module tb_mem_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          i_stall;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          d_stall;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Bench-owned memory contents; unwritten words read as a hash of the address.
    logic [15:0] mem_arr [int];
    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] rnd_addr();
        return 16'($urandom_range(0, 15) * 2);
    endfunction

    int          lat  = 1;
    int          pend = 0;
    bit          mute = 1'b0;
    bit          inj  = 1'b0;
    logic [15:0] p_addr;
    logic [15:0] p_wd;
    logic        p_wr;

    bit          mon_en = 1'b0;
    bit          busy   = 1'b0;
    bit          g_side;
    bit          g_wr;
    logic [15:0] g_addr;
    int          exp_done_cyc;
    bit          last_side = 1'b0;
    logic [15:0] exp_ird = '0;
    logic [15:0] exp_drd = '0;
    bit          i_got, d_got;
    bit          dlog[$];
    int          en_cyc[$];

    task automatic mem_step();
        mem_done = 1'b0;
        if (inj) begin
            mem_done  = 1'b1;
            mem_rdata = 16'hDEAD;
            inj       = 1'b0;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (p_wr) mem_arr[int'(p_addr)] = p_wd;
                else      mem_rdata = mem_rd(p_addr);
                mem_done = 1'b1;
            end
        end
        if (mem_en && !mute) begin
            p_addr = mem_addr;
            p_wr   = mem_wr;
            p_wd   = mem_wdata;
            pend   = lat;
        end
    endtask

    task automatic monitor();
        bit s;
        check_eq("i_stall", i_stall, i_req & ~i_done);
        check_eq("d_stall", d_stall, d_req & ~d_done);
        if (mem_en) begin
            check_eq("en_while_busy", busy, 0);
            check_eq("en_without_req", i_req | d_req, 1);
            s         = (i_req && d_req) ? ~last_side : d_req;
            last_side = s;
            busy      = 1'b1;
            g_side    = s;
            g_wr      = s & d_wr;
            g_addr    = s ? d_addr : i_addr;
            check_eq("mem_wr", mem_wr, g_wr);
            check_eq("mem_addr", mem_addr, g_addr);
            if (g_wr) check_eq("mem_wdata", mem_wdata, d_wdata);
            exp_done_cyc = cyc + lat + 1;
            en_cyc.push_back(cyc);
        end
        if (i_done || d_done) begin
            check_eq("done_both", i_done & d_done, 0);
            check_eq("done_while_idle", busy, 1);
            check_eq("done_side", d_done, g_side);
            check_eq("done_cycle", cyc, exp_done_cyc);
            if (!g_wr) begin
                if (g_side) exp_drd = mem_rd(g_addr);
                else        exp_ird = mem_rd(g_addr);
            end
            busy = 1'b0;
            dlog.push_back(d_done);
            i_got = i_done;
            d_got = d_done;
        end
        check_eq("i_rdata", i_rdata, exp_ird);
        check_eq("d_rdata", d_rdata, exp_drd);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        i_got = 1'b0;
        d_got = 1'b0;
        if (mon_en) monitor();
        mem_step();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst    = 1'b1;
        i_req  = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();
        rst       = 1'b0;
        busy      = 1'b0;
        last_side = 1'b0;
        exp_ird   = '0;
        exp_drd   = '0;
        pend      = 0;
        mon_en    = 1'b1;
    endtask

    task automatic wait_done(input bit side, input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            tick();
            if (side ? d_got : i_got) begin
                at = cyc;
                break;
            end
        end
        check_eq("wait_done_bound", at >= 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (i_req || d_req); k++) begin
            tick();
            if (i_got) i_req = 1'b0;
            if (d_got) d_req = 1'b0;
        end
        check_eq("drain", i_req | d_req, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int t0, at, c1, b, iw, dw, imax, dmax, ndone, nen, nst;
        logic [15:0] rd_save;
        rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_done = 0; mem_rdata = '0;
        tick();
        tick();
        check_eq("rst_flags", {i_done, d_done, mem_en, mem_wr, err}, 0);
        check_eq("rst_rdata", {i_rdata, d_rdata}, 0);
        check_eq("rst_mem", {mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Minimum-latency I read
        mem_arr[16] = 16'hABCD;
        lat = 1;
        i_req = 1; i_addr = 16'h0010; t0 = cyc;
        wait_done(0, 20, at);
        check_eq("t1_en_cycle", en_cyc[$], t0 + 1);
        check_eq("t1_done_cycle", at, t0 + 3);
        check_eq("t1_rdata", i_rdata, 16'hABCD);
        i_req = 0;
        tick();

        // Tie right after reset: D, I, D, I
        do_reset();
        b = dlog.size();
        lat = 2;
        i_req = 1; i_addr = 16'h0008;
        d_req = 1; d_wr = 0; d_addr = 16'h000A;
        for (int k = 0; k < 100 && dlog.size() < b + 4; k++) begin
            tick();
            if (i_got) i_addr = rnd_addr();
            if (d_got) d_addr = rnd_addr();
        end
        check_eq("t2_count", dlog.size() >= b + 4, 1);
        if (dlog.size() >= b + 4) begin
            check_eq("t2_grant0", dlog[b],     1);
            check_eq("t2_grant1", dlog[b + 1], 0);
            check_eq("t2_grant2", dlog[b + 2], 1);
            check_eq("t2_grant3", dlog[b + 3], 0);
        end
        drain();
        tick();

        // D write
        rd_save = exp_drd;
        d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
        at = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_en) begin at = cyc; break; end
        end
        check_eq("t3_en_seen", at >= 0, 1);
        check_eq("t3_mem_wr", mem_wr, 1);
        check_eq("t3_mem_addr", mem_addr, 16'h0020);
        check_eq("t3_mem_wdata", mem_wdata, 16'h1234);
        wait_done(1, 20, at);
        check_eq("t3_rdata_kept", d_rdata, rd_save);
        d_req = 0;
        tick();
        d_req = 1; d_wr = 0;
        wait_done(1, 20, at);
        check_eq("t3_readback", d_rdata, 16'h1234);
        d_req = 0;
        tick();

        // Back-to-back I reads, 3-cycle memory
        lat = 3;
        i_req = 1; i_addr = 16'h0000;
        wait_done(0, 20, c1);
        i_addr = 16'h0002;
        wait_done(0, 20, at);
        check_eq("t6_second_en", en_cyc[$], c1 + 2);
        check_eq("t6_second_done", at, c1 + 6);
        i_req = 0;
        tick();

        // Reset in WAIT, late mem_done afterwards
        mute = 1; lat = 1;
        i_req = 1; i_addr = 16'h0004;
        for (int k = 0; k < 10 && !mem_en; k++) tick();
        tick();
        tick();
        rst = 1; mon_en = 0;
        tick();
        rst = 0; i_req = 0;
        busy = 0; last_side = 0; exp_ird = '0; exp_drd = '0; pend = 0;
        mon_en = 1;
        tick();
        inj = 1;
        ndone = 0; nen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            ndone += int'(i_done) + int'(d_done);
            nen   += int'(mem_en);
        end
        check_eq("t4_no_done", ndone, 0);
        check_eq("t4_no_en", nen, 0);
        check_eq("t4_err", err, 0);
        mute = 0;

        // Memory never answers
        mute = 1; mon_en = 0;
        i_req = 1; i_addr = 16'h0006; t0 = cyc;
`ifdef ARB_TIMEOUT_EN
        at = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (i_done) begin at = cyc; break; end
        end
        check_eq("t5_done_cycle", at, t0 + TMO + 2);
        check_eq("t5_err", err, 1);
        check_eq("t5_rdata", i_rdata, 16'h0000);
        i_req = 0;
        for (int k = 0; k < 5; k++) tick();
        check_eq("t5_err_sticky", err, 1);
`else
        nst = 0; ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            nst   += int'(i_stall);
            ndone += int'(i_done);
        end
        check_eq("t5_stall_held", nst, 40);
        check_eq("t5_no_done", ndone, 0);
        check_eq("t5_err", err, 0);
`endif
        mute = 0;
        do_reset();
        check_eq("t5_err_cleared", err, 0);

        // Random traffic
        iw = 0; dw = 0; imax = 0; dmax = 0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            lat = $urandom_range(1, 4);
            iw = i_got ? 0 : (i_req ? iw + 1 : 0);
            dw = d_got ? 0 : (d_req ? dw + 1 : 0);
            if (iw > imax) imax = iw;
            if (dw > dmax) dmax = dw;
            if (i_req) begin
                if (i_got) begin
                    if ($urandom_range(0, 1) == 1) i_addr = rnd_addr();
                    else i_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = rnd_addr();
            end
            if (d_req) begin
                if (d_got) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d_addr = rnd_addr(); d_wr = 1'($urandom_range(0, 1));
                        d_wdata = 16'($urandom);
                    end else d_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1; d_addr = rnd_addr(); d_wr = 1'($urandom_range(0, 1));
                d_wdata = 16'($urandom);
            end
        end
        drain();
        check_eq("rand_i_wait_bounded", imax <= 20, 1);
        check_eq("rand_d_wait_bounded", dmax <= 20, 1);
        check_eq("rand_activity", dlog.size() > 100, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
